vga_timing_core: RTL and testbench

//  Parametrised VGA raster timing generator. Replaces the fixed 794x523 free-running counter pair.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_button_debounce.sv | 50 +++++
 rtl/vga_timing_core.sv | 147 ++++++++++++++
 tb/tb_vga_timing_core.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing defaults, total helper and line-region type
// Shared by vga_timing_core, vga_button_debounce and VGADrawer.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam bit DEF_HS_POL     = 1'b0;
    localparam bit DEF_VS_POL     = 1'b0;
    localparam int DEF_NUM_BANKS  = 4;
    localparam int DEF_DEB_CYCLES = 500000;

    // Order of regions within a line (or frame): active, front porch, sync, back porch.
    typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} region_t;

    function automatic int calc_total(input int a, input int fp, input int s, input int bp);
        return a + fp + s + bp;
    endfunction

endpackage

// File: rtl/vga_button_debounce.sv
// rtl/vga_button_debounce.sv - synchroniser and debouncer for an active-low push-button
// Ports:
//   Clk, Reset_n   system clock, asynchronous active-low reset
//   raw_n          raw button level (low = pressed), asynchronous to Clk
//   stable         debounced level (1 = released)
//   press_pulse    one Clk pulse when the debounced level falls 1->0
module vga_button_debounce
    import vga_timing_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
)(
    input  logic Clk,
    input  logic Reset_n,
    input  logic raw_n,
    output logic stable,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // The counter only runs while the synchronised level differs from the accepted
    // level; any return to the accepted level restarts the qualification window.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            stable      <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= raw_n;
            sync2       <= sync1;
            press_pulse <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                stable      <= sync2;
                cnt         <= '0;
                press_pulse <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - parametrised VGA raster timing generator with frame-buffer bank select
// Ports:
//   Clk, Reset_n         system clock, asynchronous active-low reset
//   Pulsador             active-low push-button, cycles banks when SelMode=0
//   FileSW[3:0]          direct bank number when SelMode=1 (clamped to NUM_BANKS-1)
//   SelMode              0 = button, 1 = FileSW
//   PixEn                one-Clk pixel enable; pixel outputs change only with it
//   VGA_Clk              DAC pixel clock, high for the first half of each pixel period
//   Hsync, Vsync         syncs with polarity HS_POL / VS_POL
//   VGA_blank            1 only inside the active area; VGA_sync tied 0
//   Columna, Fila        horizontal / vertical counters; Activo = inside active area
//   FrameStart           pulse on the PixEn where the counters become (0,0)
//   BankSel              bank the VRAM reader displays, updated only at FrameStart
module vga_timing_core
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = DEF_HS_POL,
    parameter bit VS_POL     = DEF_VS_POL,
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
)(
    input  logic                                                       Clk,
    input  logic                                                       Reset_n,
    input  logic                                                       Pulsador,
    input  logic [3:0]                                                 FileSW,
    input  logic                                                       SelMode,
    output logic                                                       PixEn,
    output logic                                                       VGA_Clk,
    output logic                                                       Hsync,
    output logic                                                       Vsync,
    output logic                                                       VGA_blank,
    output logic                                                       VGA_sync,
    output logic [$clog2(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP))-1:0] Columna,
    output logic [$clog2(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP))-1:0] Fila,
    output logic                                                       Activo,
    output logic                                                       FrameStart,
    output logic [$clog2(NUM_BANKS)-1:0]                               BankSel
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int CW      = $clog2(H_TOTAL);
    localparam int RW      = $clog2(V_TOTAL);
    localparam int BW      = $clog2(NUM_BANKS);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic          col_last;
    logic          row_last;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          act_nxt;
    logic [BW-1:0] pending;
    logic [BW-1:0] pending_inc;
    logic [BW-1:0] sw_clamped;
    logic          btn_stable;
    logic          press_pulse;

    // With CLK_DIV=1 the divider never leaves 0, so PixEn and VGA_Clk stay high.
    assign PixEn    = (div == DW'(CLK_DIV - 1));
    assign VGA_Clk  = (div < DW'((CLK_DIV + 1) / 2));
    assign VGA_sync = 1'b0;

    assign col_last   = (Columna == CW'(H_TOTAL - 1));
    assign row_last   = (Fila == RW'(V_TOTAL - 1));
    assign FrameStart = PixEn & col_last & row_last;

    // Decode from the next counter value so the registered syncs/blank line up
    // with Columna/Fila in the same cycle.
    always_comb begin
        col_nxt = col_last ? '0 : Columna + CW'(1);
        row_nxt = Fila;
        if (col_last) begin
            row_nxt = row_last ? '0 : Fila + RW'(1);
        end
        hs_nxt  = (col_nxt >= CW'(H_ACTIVE + H_FP)) && (col_nxt < CW'(H_ACTIVE + H_FP + H_SYNC));
        vs_nxt  = (row_nxt >= RW'(V_ACTIVE + V_FP)) && (row_nxt < RW'(V_ACTIVE + V_FP + V_SYNC));
        act_nxt = (col_nxt < CW'(H_ACTIVE)) && (row_nxt < RW'(V_ACTIVE));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div       <= '0;
            Columna   <= '0;
            Fila      <= '0;
            Hsync     <= ~HS_POL;
            Vsync     <= ~VS_POL;
            VGA_blank <= 1'b1;
            Activo    <= 1'b1;
        end else begin
            div <= PixEn ? '0 : div + DW'(1);
            if (PixEn) begin
                Columna   <= col_nxt;
                Fila      <= row_nxt;
                Hsync     <= hs_nxt ? HS_POL : ~HS_POL;
                Vsync     <= vs_nxt ? VS_POL : ~VS_POL;
                VGA_blank <= act_nxt;
                Activo    <= act_nxt;
            end
        end
    end

    vga_button_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .raw_n       (Pulsador),
        .stable      (btn_stable),
        .press_pulse (press_pulse)
    );

    always_comb begin
        sw_clamped  = ({28'd0, FileSW} >= 32'(NUM_BANKS)) ? BW'(NUM_BANKS - 1) : BW'(FileSW);
        pending_inc = (pending == BW'(NUM_BANKS - 1)) ? '0 : pending + BW'(1);
    end

    // BankSel samples the pending value that existed before this edge, so a press
    // accepted in the FrameStart cycle only shows on the following frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending <= '0;
            BankSel <= '0;
        end else begin
            if (SelMode) begin
                pending <= sw_clamped;
            end else if (press_pulse && !btn_stable) begin
                pending <= pending_inc;
            end
            if (FrameStart) begin
                BankSel <= pending;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_core.sv
// tb/tb_vga_timing_core.sv - self-checking bench for vga_timing_core (default and reduced raster)
module tb_vga_timing_core;

    localparam int S_HT    = 25;
    localparam int S_VT    = 15;
    localparam int S_FRAME = S_HT * S_VT * 2;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Pulsador;
    logic [3:0] FileSW;
    logic       SelMode;

    logic       d_pix, d_vclk, d_hs, d_vs, d_blank, d_sync, d_act, d_fs;
    logic [9:0] d_col, d_row;
    logic [1:0] d_bank;

    logic       s_pix, s_vclk, s_hs, s_vs, s_blank, s_sync, s_act, s_fs;
    logic [4:0] s_col;
    logic [3:0] s_row;
    logic [1:0] s_bank;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int bank_q[$];
    int model_pending = 0;
    int cur_bank = 0;

    always #5 Clk = ~Clk;

    vga_timing_core #(.CLK_DIV(2), .DEB_CYCLES(8)) u_dflt (
        .Clk(Clk), .Reset_n(Reset_n), .Pulsador(Pulsador), .FileSW(FileSW), .SelMode(SelMode),
        .PixEn(d_pix), .VGA_Clk(d_vclk), .Hsync(d_hs), .Vsync(d_vs), .VGA_blank(d_blank),
        .VGA_sync(d_sync), .Columna(d_col), .Fila(d_row), .Activo(d_act), .FrameStart(d_fs),
        .BankSel(d_bank)
    );

    vga_timing_core #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .NUM_BANKS(4), .DEB_CYCLES(8)
    ) u_small (
        .Clk(Clk), .Reset_n(Reset_n), .Pulsador(Pulsador), .FileSW(FileSW), .SelMode(SelMode),
        .PixEn(s_pix), .VGA_Clk(s_vclk), .Hsync(s_hs), .Vsync(s_vs), .VGA_blank(s_blank),
        .VGA_sync(s_sync), .Columna(s_col), .Fila(s_row), .Activo(s_act), .FrameStart(s_fs),
        .BankSel(s_bank)
    );

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clk);
            if (s_fs === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic press(input int low_cycles, input int high_cycles);
        Pulsador = 1'b0;
        repeat (low_cycles) @(negedge Clk);
        Pulsador = 1'b1;
        repeat (high_cycles) @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Pulsador = 1'b1; SelMode = 1'b0; FileSW = 4'd0;
        repeat (3) @(negedge Clk);
        checks++; if ({d_col, d_row} !== 20'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", d_col, d_row); end
        checks++; if ({d_hs, d_vs} !== 2'b11) begin errors++; $display("FAIL reset_syncs got %b%b want 11", d_hs, d_vs); end
        checks++; if ({d_blank, d_act, d_fs, d_sync} !== 4'b1100) begin errors++; $display("FAIL reset_flags got %b%b%b%b want 1100", d_blank, d_act, d_fs, d_sync); end
        checks++; if ({s_bank, d_bank, s_act, s_sync} !== 6'b000010) begin errors++; $display("FAIL reset_bank got %0d/%0d want 0/0", s_bank, d_bank); end
        Reset_n = 1'b1;
    endtask

    task automatic test_line_timing();
        bit         found;
        logic [9:0] prevc;
        int first_hs, hs_cnt, blank_cnt, pix_cnt, vclk_cnt, period, e;
        exp_q.push_back(1312); exp_q.push_back(192); exp_q.push_back(1280);
        exp_q.push_back(800);  exp_q.push_back(800); exp_q.push_back(1600);
        found = 1'b0;
        prevc = d_col;
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk);
            if (prevc != 10'd0 && d_col == 10'd0) begin found = 1'b1; break; end
            prevc = d_col;
        end
        checks++; if (!found) begin errors++; $display("FAIL line_start got timeout want Columna wrap"); end
        first_hs = -1; hs_cnt = 0; blank_cnt = 0; pix_cnt = 0; vclk_cnt = 0; period = -1;
        prevc = d_col;
        for (int t = 0; t < 1700; t++) begin
            if (t > 0 && prevc != 10'd0 && d_col == 10'd0) begin period = t; break; end
            if (d_hs === 1'b0) begin hs_cnt++; if (first_hs < 0) first_hs = t; end
            if (d_blank === 1'b1) blank_cnt++;
            if (d_pix === 1'b1) pix_cnt++;
            if (d_vclk === 1'b1) vclk_cnt++;
            prevc = d_col;
            @(negedge Clk);
        end
        e = exp_q.pop_front(); checks++; if (first_hs !== e) begin errors++; $display("FAIL hsync_start got %0d want %0d", first_hs, e); end
        e = exp_q.pop_front(); checks++; if (hs_cnt !== e) begin errors++; $display("FAIL hsync_width got %0d want %0d", hs_cnt, e); end
        e = exp_q.pop_front(); checks++; if (blank_cnt !== e) begin errors++; $display("FAIL blank_width got %0d want %0d", blank_cnt, e); end
        e = exp_q.pop_front(); checks++; if (pix_cnt !== e) begin errors++; $display("FAIL pixen_count got %0d want %0d", pix_cnt, e); end
        e = exp_q.pop_front(); checks++; if (vclk_cnt !== e) begin errors++; $display("FAIL vgaclk_high got %0d want %0d", vclk_cnt, e); end
        e = exp_q.pop_front(); checks++; if (period !== e) begin errors++; $display("FAIL line_period got %0d want %0d", period, e); end
    endtask

    task automatic test_frame_timing();
        bit ok;
        int period, vs_cnt, vs_row, blank_late, pix_cnt, act_cnt, e;
        wait_fs(ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_start got timeout want pulse"); end
        exp_q.push_back(S_FRAME); exp_q.push_back(100); exp_q.push_back(10);
        exp_q.push_back(0); exp_q.push_back(S_FRAME / 2); exp_q.push_back(256);
        period = -1; vs_cnt = 0; vs_row = -1; blank_late = 0; pix_cnt = 0; act_cnt = 0;
        for (int t = 1; t <= 2000; t++) begin
            @(negedge Clk);
            if (s_vs === 1'b0) begin vs_cnt++; if (vs_row < 0) vs_row = int'(s_row); end
            if (s_blank === 1'b1 && s_row >= 4'd8) blank_late++;
            if (s_pix === 1'b1 && s_vclk === 1'b0) pix_cnt++;
            if (s_act === 1'b1) act_cnt++;
            if (s_fs === 1'b1) begin period = t; break; end
        end
        e = exp_q.pop_front(); checks++; if (period !== e) begin errors++; $display("FAIL frame_period got %0d want %0d", period, e); end
        e = exp_q.pop_front(); checks++; if (vs_cnt !== e) begin errors++; $display("FAIL vsync_width got %0d want %0d", vs_cnt, e); end
        e = exp_q.pop_front(); checks++; if (vs_row !== e) begin errors++; $display("FAIL vsync_row got %0d want %0d", vs_row, e); end
        e = exp_q.pop_front(); checks++; if (blank_late !== e) begin errors++; $display("FAIL blank_vertical got %0d want %0d", blank_late, e); end
        e = exp_q.pop_front(); checks++; if (pix_cnt !== e) begin errors++; $display("FAIL frame_pixen got %0d want %0d", pix_cnt, e); end
        e = exp_q.pop_front(); checks++; if (act_cnt !== e) begin errors++; $display("FAIL frame_active got %0d want %0d", act_cnt, e); end
    endtask

    task automatic test_bank_cycle(input int n_press);
        bit ok;
        int e;
        wait_fs(ok);
        @(negedge Clk);
        for (int i = 0; i < n_press; i++) press(20, 20);
        model_pending = (model_pending + n_press) % 4;
        bank_q.push_back(model_pending);
        checks++; if (s_bank !== 2'(cur_bank)) begin errors++; $display("FAIL bank_midframe got %0d want %0d", s_bank, cur_bank); end
        wait_fs(ok);
        checks++; if (!ok || s_bank !== 2'(cur_bank)) begin errors++; $display("FAIL bank_before_commit got %0d want %0d", s_bank, cur_bank); end
        @(negedge Clk);
        e = bank_q.pop_front();
        checks++; if (s_bank !== 2'(e)) begin errors++; $display("FAIL bank_cycle_%0d got %0d want %0d", n_press, s_bank, e); end
        cur_bank = e;
    endtask

    task automatic test_mode1();
        bit ok;
        int e;
        SelMode = 1'b1;
        FileSW = 4'd2; model_pending = 2; bank_q.push_back(model_pending);
        press(20, 20);
        wait_fs(ok);
        @(negedge Clk);
        e = bank_q.pop_front();
        checks++; if (!ok || s_bank !== 2'(e)) begin errors++; $display("FAIL mode1_sw2 got %0d want %0d", s_bank, e); end
        FileSW = 4'd9; model_pending = 3; bank_q.push_back(model_pending);
        wait_fs(ok);
        @(negedge Clk);
        e = bank_q.pop_front();
        checks++; if (!ok || s_bank !== 2'(e)) begin errors++; $display("FAIL mode1_clamp got %0d want %0d", s_bank, e); end
        cur_bank = e;
        SelMode = 1'b0;
    endtask

    task automatic test_debounce();
        bit ok;
        int e;
        for (int i = 0; i < 3; i++) press(5, 20);
        press(8, 20);
        model_pending = (model_pending + 1) % 4;
        bank_q.push_back(model_pending);
        wait_fs(ok);
        @(negedge Clk);
        e = bank_q.pop_front();
        checks++; if (!ok || s_bank !== 2'(e)) begin errors++; $display("FAIL debounce got %0d want %0d", s_bank, e); end
        cur_bank = e;
    endtask

    task automatic test_back_to_back_commit();
        bit ok;
        int e;
        wait_fs(ok);
        repeat (S_FRAME - 10) @(negedge Clk);
        Pulsador = 1'b0;
        bank_q.push_back(model_pending);
        model_pending = (model_pending + 1) % 4;
        bank_q.push_back(model_pending);
        repeat (10) @(negedge Clk);
        checks++; if (s_fs !== 1'b1) begin errors++; $display("FAIL coincident_align got %b want 1", s_fs); end
        @(negedge Clk);
        e = bank_q.pop_front();
        checks++; if (s_bank !== 2'(e)) begin errors++; $display("FAIL coincident_old got %0d want %0d", s_bank, e); end
        repeat (10) @(negedge Clk);
        Pulsador = 1'b1;
        wait_fs(ok);
        @(negedge Clk);
        e = bank_q.pop_front();
        checks++; if (!ok || s_bank !== 2'(e)) begin errors++; $display("FAIL coincident_next got %0d want %0d", s_bank, e); end
        cur_bank = e;
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clk);
            if (s_row == 4'd10 && s_col == 5'd7) begin found = 1'b1; break; end
        end
        checks++; if (!found || s_vs !== 1'b0) begin errors++; $display("FAIL midframe_setup got row %0d vs %b want row 10 vs 0", s_row, s_vs); end
        Reset_n = 1'b0;
        #1;
        checks++; if ({s_col, s_row} !== 9'd0) begin errors++; $display("FAIL midreset_counters got %0d/%0d want 0/0", s_col, s_row); end
        checks++; if ({s_hs, s_vs} !== 2'b11) begin errors++; $display("FAIL midreset_syncs got %b%b want 11", s_hs, s_vs); end
        checks++; if (s_bank !== 2'd0) begin errors++; $display("FAIL midreset_bank got %0d want 0", s_bank); end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_bank_cycle(3);
        test_bank_cycle(2);
        test_mode1();
        test_debounce();
        test_back_to_back_commit();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
